wb_cmd_initiator: RTL and testbench

- Wishbone classic initiator: the bus-master end of the peripheral register interface used by the SoC controllers (system controller, display, interrupt-enable registers).
- Accepts single-word read/write commands on a valid/ready port and runs exactly one Wishbone cycle per command.
- Returns read data and an error status on a valid/ready response port.
- Used by debug/bring-up logic and test sequencers to drive peripheral register maps without the CPU.

---
 rtl/wb_init_pkg.sv | 15 +
 rtl/wb_cmd_initiator.sv | 131 +++++++++++++
 tb/tb_wb_cmd_initiator.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_init_pkg.sv
// Shared types for the Wishbone command initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_init_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one bus cycle per command, response with data/err.
// Latency: cyc after cmd edge, rsp_valid the edge ack/err/timeout is sampled.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready.
module wb_cmd_initiator
  import wb_init_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    i_cmd_adr,
  input  logic [WB_DW-1:0]         i_cmd_dat,
  input  logic [WB_SELW-1:0]       i_cmd_sel,
  input  logic                     i_cmd_we,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WB_DW-1:0]         o_rsp_dat,
  output logic                     o_rsp_err,
  output logic [ADDR_WIDTH-1:0]    o_wb_adr,
  output logic [WB_DW-1:0]         o_wb_dat,
  output logic [WB_SELW-1:0]       o_wb_sel,
  output logic                     o_wb_we,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  input  logic [WB_DW-1:0]         i_wb_rdt,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int TW     = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmo_q;
  logic                 cmd_fire, bus_ok, bus_fail;
  logic [ADDR_WIDTH-1:0] wb_adr_q;
  logic [WB_DW-1:0]     wb_dat_q;
  logic [WB_SELW-1:0]   wb_sel_q;
  logic                 wb_we_q, wb_cyc_q;
  logic [WB_DW-1:0]     rsp_dat_q;
  logic                 rsp_err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // err beats ack, ack beats timeout when they land in the same cycle
  always_comb begin
    state_d  = state_q;
    cmd_fire = 1'b0;
    bus_ok   = 1'b0;
    bus_fail = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          cmd_fire = 1'b1;
          state_d  = BUS;
        end
      end
      BUS: begin
        if (i_wb_err) begin
          bus_fail = 1'b1;
          state_d  = RESP;
        end else if (i_wb_ack) begin
          bus_ok  = 1'b1;
          state_d = RESP;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          bus_fail = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_adr_q  <= '0;
      wb_dat_q  <= '0;
      wb_sel_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_cyc_q  <= 1'b0;
      tmo_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (cmd_fire) begin
        wb_adr_q <= i_cmd_adr;
        wb_dat_q <= i_cmd_dat;
        wb_sel_q <= i_cmd_sel;
        wb_we_q  <= i_cmd_we;
        wb_cyc_q <= 1'b1;
        tmo_q    <= '0;
      end else if (state_q == BUS) begin
        tmo_q <= tmo_q + 1'b1;
      end
      // cyc must fall on the exit edge or the responder acks again
      if (bus_ok || bus_fail) begin
        wb_cyc_q  <= 1'b0;
        rsp_err_q <= bus_fail;
        rsp_dat_q <= (bus_ok && !wb_we_q) ? i_wb_rdt : '0;
      end
      if (bus_fail && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_adr    = wb_adr_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_wb_sel    = wb_sel_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_cyc    = wb_cyc_q;
  assign o_wb_stb    = wb_cyc_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Scoreboard bench: driver pushes expected responses, a negedge monitor pops them.
// Responder is a behavioural Wishbone slave with wait states, err and no-ack modes.
module tb_wb_cmd_initiator;

  localparam int AW  = 6;
  localparam int TMO = 8;
  localparam int ECW = 8;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [AW-1:0]  i_cmd_adr;
  logic [31:0]    i_cmd_dat;
  logic [3:0]     i_cmd_sel;
  logic           i_cmd_we;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic [31:0]    o_rsp_dat;
  logic           o_rsp_err;
  logic [AW-1:0]  o_wb_adr;
  logic [31:0]    o_wb_dat;
  logic [3:0]     o_wb_sel;
  logic           o_wb_we;
  logic           o_wb_cyc;
  logic           o_wb_stb;
  logic [31:0]    i_wb_rdt;
  logic           i_wb_ack;
  logic           i_wb_err;
  logic [ECW-1:0] o_err_cnt;

  wb_cmd_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(ECW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel), .i_cmd_we(i_cmd_we),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  // mode 0 = ack after wait states, 1 = err, 2 = ack+err together, 3 = never answer
  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cnt;
    int          cyc_len;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];
  int          exp_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rsp_mode = 0;
  int          rsp_wait = 0;
  int          ready_mode = 0;
  int          cyc_cnt = 0;
  logic [AW-1:0] cur_adr;
  logic [31:0]   cur_dat;
  logic [3:0]    cur_sel;
  logic          cur_we;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Slave: registered ack/err, one pulse per cycle, random noise while cyc is low
  initial begin : responder
    int seen;
    int idx;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_rdt = '0;
    seen = 0;
    forever begin
      @(posedge i_clk);
      #1;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_wb_rdt = $urandom;
      if (!o_wb_cyc) begin
        seen = 0;
        if ($urandom_range(7) == 0) i_wb_ack = 1'b1;
        if ($urandom_range(7) == 0) i_wb_err = 1'b1;
      end else begin
        seen++;
        if (seen == rsp_wait + 2) begin
          idx = int'(o_wb_adr[5:2]);
          case (rsp_mode)
            0: begin
              i_wb_ack = 1'b1;
              if (o_wb_we) begin
                for (int b = 0; b < 4; b++)
                  if (o_wb_sel[b]) slv_mem[idx][8*b +: 8] = o_wb_dat[8*b +: 8];
              end else begin
                i_wb_rdt = slv_mem[idx];
              end
            end
            1: i_wb_err = 1'b1;
            2: begin
              i_wb_ack = 1'b1;
              i_wb_err = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  initial begin : ready_driver
    i_rsp_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0:       i_rsp_ready = 1'b1;
        1:       i_rsp_ready = ($urandom_range(1) == 1);
        default: i_rsp_ready = 1'b0;
      endcase
    end
  end

  always @(negedge i_clk) begin : monitor
    if (!i_rst_n) begin
      cyc_cnt = 0;
    end else begin
      check("stb_eq_cyc", 64'(o_wb_stb), 64'(o_wb_cyc));
      if (o_wb_cyc) begin
        cyc_cnt++;
        check("wb_adr_hold", 64'(o_wb_adr), 64'(cur_adr));
        check("wb_dat_hold", 64'(o_wb_dat), 64'(cur_dat));
        check("wb_sel_hold", 64'(o_wb_sel), 64'(cur_sel));
        check("wb_we_hold", 64'(o_wb_we), 64'(cur_we));
      end
      if (o_rsp_valid) begin
        check("cmd_ready_in_resp", 64'(o_cmd_ready), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
        end else begin
          check("rsp_dat", 64'(o_rsp_dat), 64'(exp_q[0].dat));
          check("rsp_err", 64'(o_rsp_err), 64'(exp_q[0].err));
          check("err_cnt", 64'(o_err_cnt), 64'(exp_q[0].cnt));
          if (i_rsp_ready) begin
            check("cyc_len", 64'(cyc_cnt), 64'(exp_q[0].cyc_len));
            cyc_cnt = 0;
            exp_q.delete(0);
          end
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input int mode, input int wt);
    exp_t e;
    int   guard;
    int   idx;
    bit   done;
    @(posedge i_clk);
    #1;
    guard = 0;
    while (o_wb_cyc && guard < 100) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    if (o_wb_cyc) bound_expired("cyc_idle_wait");
    rsp_mode = mode;
    rsp_wait = wt;
    cur_adr = adr;
    cur_dat = dat;
    cur_sel = sel;
    cur_we = we;
    i_cmd_adr = adr;
    i_cmd_dat = dat;
    i_cmd_sel = sel;
    i_cmd_we = we;
    i_cmd_valid = 1'b1;
    idx = int'(adr[5:2]);
    e.cyc_len = (mode == 3) ? TMO : wt + 2;
    if (mode == 0) begin
      e.err = 1'b0;
      if (we) begin
        e.dat = '0;
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end else begin
        e.dat = ref_mem[idx];
      end
    end else begin
      e.err = 1'b1;
      e.dat = '0;
      if (exp_cnt < 255) exp_cnt++;
    end
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge i_clk);
      if (o_cmd_ready) done = 1'b1;
    end
    if (!done) bound_expired("cmd_accept");
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_adr = AW'($urandom);
    i_cmd_dat = $urandom;
    i_cmd_sel = 4'($urandom);
    i_cmd_we = 1'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge i_clk);
      guard++;
    end
    if (exp_q.size() != 0) bound_expired("drain");
  endtask

  task automatic rand_cmd(input bit errs_only);
    int m;
    m = errs_only ? int'($urandom_range(3, 1)) : (($urandom_range(9) < 7) ? 0 : int'($urandom_range(3, 1)));
    issue(AW'($urandom), $urandom, 4'($urandom), 1'($urandom), m, int'($urandom_range(6)));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] held;
    bit got;
    i_rst_n = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_adr = '0;
    i_cmd_dat = '0;
    i_cmd_sel = '0;
    i_cmd_we = 1'b0;
    cur_adr = '0; cur_dat = '0; cur_sel = '0; cur_we = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[0] = 32'h00FF_0102; ref_mem[0] = 32'h00FF_0102;
    slv_mem[6] = 32'h0;         ref_mem[6] = 32'h0;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_cyc", 64'(o_wb_cyc), 64'd0);
    check("rst_stb", 64'(o_wb_stb), 64'd0);
    check("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    check("rst_rsp_dat", 64'(o_rsp_dat), 64'd0);
    check("rst_wb_we", 64'(o_wb_we), 64'd0);
    i_rst_n = 1'b1;

    issue(6'h00, 32'h0, 4'hF, 1'b0, 0, 0);
    wait_drain();
    issue(6'h18, 32'h3, 4'h1, 1'b1, 0, 0);
    issue(6'h18, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, 2);
    issue(6'h04, 32'h0, 4'hF, 1'b0, 3, 0);
    issue(6'h08, 32'h0, 4'hF, 1'b0, 2, 1);
    issue(6'h0C, 32'h0, 4'hF, 1'b0, 0, TMO - 2);
    wait_drain();

    ready_mode = 2;
    fork
      begin
        issue(6'h00, 32'h0, 4'hF, 1'b0, 0, 1);
        issue(6'h18, 32'h0, 4'hF, 1'b0, 0, 0);
      end
      begin
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge i_clk);
          if (o_rsp_valid) got = 1'b1;
        end
        if (!got) bound_expired("stall_rsp_wait");
        held = o_rsp_dat;
        for (int i = 0; i < 5; i++) begin
          check("stall_valid", 64'(o_rsp_valid), 64'd1);
          check("stall_cmd_ready", 64'(o_cmd_ready), 64'd0);
          check("stall_dat", 64'(o_rsp_dat), 64'(held));
          @(negedge i_clk);
        end
        ready_mode = 0;
      end
    join
    wait_drain();

    ready_mode = 1;
    for (int i = 0; i < 300; i++) rand_cmd(1'b1);
    wait_drain();
    check("err_cnt_saturated", 64'(o_err_cnt), 64'd255);
    for (int i = 0; i < 200; i++) rand_cmd(1'b0);
    ready_mode = 0;
    wait_drain();

    issue(6'h10, 32'h0, 4'hF, 1'b0, 3, 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_cyc", 64'(o_wb_cyc), 64'd0);
    check("arst_stb", 64'(o_wb_stb), 64'd0);
    check("arst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("post_rst_ready", 64'(o_cmd_ready), 64'd1);
      check("post_rst_no_rsp", 64'(o_rsp_valid), 64'd0);
    end
    check("post_rst_err_cnt", 64'(o_err_cnt), 64'd0);
    issue(6'h00, 32'h0, 4'hF, 1'b0, 0, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
